vedic_mult_pipe: RTL and testbench

//  Parametrised, pipelined Urdhva-Tiryagbhyam (Vedic) multiplier: WIDTH x WIDTH -> 2*WIDTH.

---
 rtl/vedic_mult_pipe_pkg.sv | 23 ++
 rtl/vedic_mult_core.sv | 38 +++
 rtl/vedic_mult_pipe.sv | 147 ++++++++++++++
 tb/tb_vedic_mult_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_mult_pipe_pkg.sv
// ----------------------------------------------------------------------------
// vedic_pkg
// Shared helpers for the pipelined Vedic multiplier:
//   MIN_WIDTH / MAX_WIDTH  legal operand width range
//   width_ok()             elaboration-time operand width legality check
//   csa3()                 single-bit 3:2 compressor, returns {sum, carry}
// Width-dependent types (HALF, s1_t) live in vedic_mult_pipe because a
// package cannot see the module's parameters.
// ----------------------------------------------------------------------------
package vedic_pkg;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 32;

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH) && ((w & (w - 1)) == 0);
    endfunction

    function automatic logic [1:0] csa3(input logic a, input logic b, input logic c);
        return {a ^ b ^ c, (a & b) | (a & c) | (b & c)};
    endfunction

endpackage

// File: rtl/vedic_mult_core.sv
// ----------------------------------------------------------------------------
// vedic_mult_core
// Combinational N x N unsigned Urdhva-Tiryagbhyam multiplier. Recurses on
// operand halves down to a 2x2 leaf built from ANDs and half-adders.
// Ports:
//   a, b  in  N    operands
//   p     out 2*N  product
// ----------------------------------------------------------------------------
module vedic_mult_core #(
    parameter int N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    if (N == 2) begin : g_leaf
        logic c1;
        // Cross terms a1b0 and a0b1 meet in a half-adder; its carry joins a1b1.
        assign p[0] = a[0] & b[0];
        assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
        assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
        assign p[2] = (a[1] & b[1]) ^ c1;
        assign p[3] = (a[1] & b[1]) & c1;
    end else begin : g_split
        localparam int H = N / 2;
        logic [N-1:0] ll, hl, lh, hh;

        vedic_mult_core #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
        vedic_mult_core #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl));
        vedic_mult_core #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh));
        vedic_mult_core #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));

        assign p = (2*N)'(ll) + ((2*N)'(hl) << H) + ((2*N)'(lh) << H)
                 + {hh, {N{1'b0}}};
    end

endmodule

// File: rtl/vedic_mult_pipe.sv
// ----------------------------------------------------------------------------
// vedic_mult_pipe
// Two-stage pipelined WIDTH x WIDTH -> 2*WIDTH Vedic multiplier with a
// valid/ready handshake on both sides, full throughput and back-pressure.
//   S1: four (WIDTH/2)^2 sub-products + tag (+ sign) registered.
//   S2: carry-save sum of the sub-products registered as out_p/out_tag.
// Optional feature macro: VEDIC_MULT_SIGNED_EN adds in_signed; when set the
// operands are two's complement (magnitudes multiplied, sign applied in S2).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 synchronous drop of all in-flight operations
//   in_valid/in_ready     operand handshake; in_a, in_b, in_tag payload
//   in_signed             (macro only) signed operation select
//   out_valid/out_ready   result handshake; out_p, out_tag payload
//   busy                  any stage holds a valid operation
// ----------------------------------------------------------------------------
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef VEDIC_MULT_SIGNED_EN
    input  logic               in_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int HALF = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;

    if (!width_ok(WIDTH) || TAG_W < 1) begin : g_bad_param
        $error("vedic_mult_pipe: WIDTH must be a power of two in 4..32 and TAG_W >= 1");
    end

    typedef struct packed {
        logic [WIDTH-1:0] ll;
        logic [WIDTH-1:0] hl;
        logic [WIDTH-1:0] lh;
        logic [WIDTH-1:0] hh;
        logic [TAG_W-1:0] tag;
        logic             sign;
    } s1_t;

    logic s1_valid, s2_valid, s1_load, s2_load;
    s1_t  s1_d, s1_q;

    // ---------------- operand conditioning ----------------
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_sign;

`ifdef VEDIC_MULT_SIGNED_EN
    // Magnitude of -2^(W-1) is 2^(W-1), which still fits W unsigned bits.
    assign op_a    = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    assign op_b    = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    assign op_sign = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
`else
    assign op_a    = in_a;
    assign op_b    = in_b;
    assign op_sign = 1'b0;
`endif

    vedic_mult_core #(.N(HALF)) u_ll (.a(op_a[HALF-1:0]),     .b(op_b[HALF-1:0]),     .p(s1_d.ll));
    vedic_mult_core #(.N(HALF)) u_hl (.a(op_a[WIDTH-1:HALF]), .b(op_b[HALF-1:0]),     .p(s1_d.hl));
    vedic_mult_core #(.N(HALF)) u_lh (.a(op_a[HALF-1:0]),     .b(op_b[WIDTH-1:HALF]), .p(s1_d.lh));
    vedic_mult_core #(.N(HALF)) u_hh (.a(op_a[WIDTH-1:HALF]), .b(op_b[WIDTH-1:HALF]), .p(s1_d.hh));
    assign s1_d.tag  = in_tag;
    assign s1_d.sign = op_sign;

    // ---------------- handshake ----------------
    // flush masks both loads so nothing new enters while the pipe is cleared.
    assign s2_load   = ~flush & s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~flush & (~s1_valid | s2_load);
    assign s1_load   = in_valid & in_ready;
    assign out_valid = s2_valid;
    assign busy      = s1_valid | s2_valid;

    // ---------------- S2 carry-save reduction ----------------
    logic [PW-1:0] t_ll, t_hl, t_lh, t_hh;
    logic [PW-1:0] sum0, cy0, sum1, cy1, prod, prod_fin;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        t_ll = PW'(s1_q.ll);
        t_hl = PW'(s1_q.hl) << HALF;
        t_lh = PW'(s1_q.lh) << HALF;
        t_hh = {s1_q.hh, {WIDTH{1'b0}}};
        sum0 = '0;
        cy0  = '0;
        sum1 = '0;
        cy1  = '0;
        // Carries are written one bit up; the carry out of the top bit falls
        // outside mod 2^PW and is simply not formed.
        for (int i = 0; i < PW - 1; i++) begin
            {sum0[i], cy0[i+1]} = csa3(t_ll[i], t_hl[i], t_lh[i]);
        end
        sum0[PW-1] = t_ll[PW-1] ^ t_hl[PW-1] ^ t_lh[PW-1];
        for (int i = 0; i < PW - 1; i++) begin
            {sum1[i], cy1[i+1]} = csa3(sum0[i], cy0[i], t_hh[i]);
        end
        sum1[PW-1] = sum0[PW-1] ^ cy0[PW-1] ^ t_hh[PW-1];
        prod     = sum1 + cy1;
        prod_fin = s1_q.sign ? -prod : prod;
    end

    // ---------------- stage registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: payload registers are reset too, so out_p/out_tag read 0 after
    // reset and no stale partial result can surface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            out_p    <= '0;
            out_tag  <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                s1_valid <= s1_load | (s1_valid & ~s2_load);
                s2_valid <= s2_load | (s2_valid & ~out_ready);
            end
            if (s1_load) s1_q <= s1_d;
            if (s2_load) begin
                out_p   <= prod_fin;
                out_tag <= s1_q.tag;
            end
        end
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// ----------------------------------------------------------------------------
// tb_vedic_mult_pipe
// Scoreboard bench: the driver pushes expected {product, tag} on each accept;
// a monitor pops and compares on every out_valid & out_ready transfer and
// also checks that a stalled output holds still.
// ----------------------------------------------------------------------------
module tb_vedic_mult_pipe;

    localparam int W     = 8;
    localparam int TAG_W = 4;
    localparam int PW    = 2 * W;

    typedef struct {
        logic [PW-1:0]    p;
        logic [TAG_W-1:0] tag;
        int               acc_cyc;
        bit               chk_lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]     in_a, in_b;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [PW-1:0]    out_p;
    logic             in_signed;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    vedic_mult_pipe #(.WIDTH(W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
`ifdef VEDIC_MULT_SIGNED_EN
        .in_signed (in_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference product straight from integer arithmetic.
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sgn);
        logic signed [PW-1:0] sa, sb;
        logic        [PW-1:0] ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        return sgn ? PW'(sa * sb) : ua * ub;
    endfunction

    task automatic push(input logic [PW-1:0] p, input logic [TAG_W-1:0] tag, input bit lat);
        exp_t e;
        e.p       = p;
        e.tag     = tag;
        e.acc_cyc = cyc;
        e.chk_lat = lat;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic             stall_prev = 1'b0;
    logic [PW-1:0]    prev_p;
    logic [TAG_W-1:0] prev_tag;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_p", 64'(out_p), 64'(prev_p));
                check("stall_hold_tag", 64'(out_tag), 64'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_out: got out_p=0x%0h tag=%0h, expected no result", out_p, out_tag);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("product", 64'(out_p), 64'(e.p));
                    check("tag", 64'(out_tag), 64'(e.tag));
                    if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'd2);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_p     = out_p;
            prev_tag   = out_tag;
        end
    end

    // ---------------- driver helpers (entered at posedge + 1) ----------------
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TAG_W-1:0] tag,
                         input logic sgn, input logic [PW-1:0] exp, input bit lat);
        bit acc = 1'b0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        in_signed = sgn;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (in_ready) begin
                push(exp, tag, lat);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL issue_timeout: got no accept in 50 cycles, expected in_ready");
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && (exp_q.size() != 0 || busy); k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_busy", 64'(busy), 64'd0);
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_acc;
        int issued;
        bit acc;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_tag = '0; in_signed = 1'b0;

        // Reset / idle
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_p", 64'(out_p), 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Corners, back-to-back, with literal expected products
        issue(8'h00, 8'h55, 4'h1, 1'b0, 16'h0000, 1'b1);
        issue(8'hFF, 8'hFF, 4'h2, 1'b0, 16'hFE01, 1'b1);
        issue(8'h0F, 8'hF0, 4'h3, 1'b0, 16'h0E10, 1'b1);
        issue(8'h80, 8'h02, 4'h4, 1'b0, 16'h0100, 1'b1);
        wait_drain();

`ifdef VEDIC_MULT_SIGNED_EN
        issue(8'hFD, 8'h05, 4'h5, 1'b1, 16'hFFF1, 1'b1);
        issue(8'h80, 8'h80, 4'h6, 1'b1, 16'h4000, 1'b1);
        issue(8'h80, 8'h80, 4'h7, 1'b0, 16'h4000, 1'b1);
        issue(8'hFF, 8'hFF, 4'h8, 1'b1, 16'h0001, 1'b1);
        wait_drain();
`endif

        // Back-pressure: consumer stalled for 5 cycles during a stream
        out_ready = 1'b0;
        n_acc     = 0;
        in_valid  = 1'b1;
        in_a = W'($urandom); in_b = W'($urandom); in_tag = TAG_W'(n_acc + 9);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                push(ref_mul(in_a, in_b, 1'b0), in_tag, 1'b0);
                n_acc++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                in_a = W'($urandom); in_b = W'($urandom); in_tag = TAG_W'(n_acc + 9);
            end
        end
        in_valid = 1'b0;
        check("bp_accepts", 64'(n_acc), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        wait_drain();

        // Flush with both stages full
        out_ready = 1'b0;
        issue(8'h12, 8'h34, 4'hA, 1'b0, ref_mul(8'h12, 8'h34, 1'b0), 1'b0);
        issue(8'h56, 8'h78, 4'hB, 1'b0, ref_mul(8'h56, 8'h78, 1'b0), 1'b0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("flush_quiet", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges with S1 and S2 full
        out_ready = 1'b0;
        issue(8'h9A, 8'hBC, 4'hC, 1'b0, ref_mul(8'h9A, 8'hBC, 1'b0), 1'b0);
        issue(8'hDE, 8'hF1, 4'hD, 1'b0, ref_mul(8'hDE, 8'hF1, 1'b0), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("areset_out_valid", 64'(out_valid), 64'd0);
        check("areset_busy", 64'(busy), 64'd0);
        check("areset_out_p", 64'(out_p), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("areset_quiet", 64'(out_valid), 64'd0);

        // Random traffic with random stalls
        issued = 0;
        for (int k = 0; k < 20000 && issued < 2000; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid  = 1'b1;
                in_a      = W'($urandom);
                in_b      = W'($urandom);
                in_tag    = TAG_W'(issued);
`ifdef VEDIC_MULT_SIGNED_EN
                in_signed = 1'($urandom);
`else
                in_signed = 1'b0;
`endif
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) begin
                push(ref_mul(in_a, in_b, in_signed), in_tag, 1'b0);
                issued++;
            end
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("random_issued", 64'(issued), 64'd2000);
        out_ready = 1'b1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
